// File: rtl/ram_arb_pkg.sv
// Grant encoding and default widths shared by the RAM arbiter files.
package ram_arb_pkg;

  localparam int ADDR_WIDTH_DEF      = 11;
  localparam int DATA_WIDTH_DEF      = 8;
  localparam int VIDEO_MAX_BURST_DEF = 8;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_VID  = 2'd1,
    GNT_CPU  = 2'd2,
    GNT_AUD  = 2'd3
  } gnt_e;

endpackage

// File: rtl/ram_arb_sel.sv
// Grant decision for the RAM arbiter: video priority, burst limit, CPU/audio round-robin.
// Audio requester present only when RAM_ARBITER_AUDIO_EN is defined.
module ram_arb_sel
  import ram_arb_pkg::*;
#(
  parameter int VIDEO_MAX_BURST = VIDEO_MAX_BURST_DEF
) (
  input  logic clk,
  input  logic reset_n,
  input  logic vid_req,
  input  logic cpu_req,
`ifdef RAM_ARBITER_AUDIO_EN
  input  logic aud_req,
`endif
  output gnt_e gnt
);

  localparam int                BURST_W   = $clog2(VIDEO_MAX_BURST + 1);
  localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(VIDEO_MAX_BURST);

  gnt_e               gnt_r;
  gnt_e               gnt_s;
  gnt_e               sec_gnt_s;
  logic [BURST_W-1:0] burst_r;
  logic [BURST_W-1:0] burst_s;
  logic               vid_ok_s;
  logic               cpu_ok_s;
  logic               any_req_s;
`ifdef RAM_ARBITER_AUDIO_EN
  logic               aud_ok_s;
  logic               rr_r;
  logic               rr_s;
`endif

  // Next grant, burst count and round-robin pointer; the port in its grant cycle is masked
  always_comb begin
    gnt_s     = GNT_NONE;
    sec_gnt_s = GNT_NONE;
    burst_s   = burst_r;
    vid_ok_s  = vid_req && (gnt_r != GNT_VID);
    cpu_ok_s  = cpu_req && (gnt_r != GNT_CPU);
`ifdef RAM_ARBITER_AUDIO_EN
    rr_s      = rr_r;
    aud_ok_s  = aud_req && (gnt_r != GNT_AUD);
    any_req_s = vid_req || cpu_req || aud_req;
    if (cpu_ok_s && aud_ok_s) begin
      sec_gnt_s = rr_r ? GNT_AUD : GNT_CPU;
    end else if (cpu_ok_s) begin
      sec_gnt_s = GNT_CPU;
    end else if (aud_ok_s) begin
      sec_gnt_s = GNT_AUD;
    end else begin
      sec_gnt_s = GNT_NONE;
    end
`else
    any_req_s = vid_req || cpu_req;
    if (cpu_ok_s) begin
      sec_gnt_s = GNT_CPU;
    end else begin
      sec_gnt_s = GNT_NONE;
    end
`endif
    // A requesting video port keeps its masked slot unless its burst allowance is spent
    if ((burst_r >= BURST_MAX) && (sec_gnt_s != GNT_NONE)) begin
      gnt_s = sec_gnt_s;
    end else if (vid_req) begin
      gnt_s = vid_ok_s ? GNT_VID : GNT_NONE;
    end else begin
      gnt_s = sec_gnt_s;
    end
    case (gnt_s)
      GNT_VID: burst_s = (burst_r < BURST_MAX) ? burst_r + BURST_W'(1) : burst_r;
      GNT_CPU: begin
        burst_s = {BURST_W{1'b0}};
`ifdef RAM_ARBITER_AUDIO_EN
        rr_s    = 1'b1;
`endif
      end
`ifdef RAM_ARBITER_AUDIO_EN
      GNT_AUD: begin
        burst_s = {BURST_W{1'b0}};
        rr_s    = 1'b0;
      end
`endif
      default: burst_s = any_req_s ? burst_r : {BURST_W{1'b0}};
    endcase
  end

  // Grant, burst and pointer registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      gnt_r   <= GNT_NONE;
      burst_r <= {BURST_W{1'b0}};
`ifdef RAM_ARBITER_AUDIO_EN
      rr_r    <= 1'b0;
`endif
    end else begin
      gnt_r   <= gnt_s;
      burst_r <= burst_s;
`ifdef RAM_ARBITER_AUDIO_EN
      rr_r    <= rr_s;
`endif
    end
  end

  assign gnt = gnt_r;

endmodule

// File: rtl/ram_arbiter.sv
// Shared single-port RAM arbiter for video, CPU and (with RAM_ARBITER_AUDIO_EN) audio.
// RAM signals follow the registered grant; ack and read data arrive one clk later.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_WIDTH      = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH      = DATA_WIDTH_DEF,
  parameter int VIDEO_MAX_BURST = VIDEO_MAX_BURST_DEF
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  vid_req,
  input  logic [ADDR_WIDTH-1:0] vid_addr,
  output logic                  vid_ack,
  output logic [DATA_WIDTH-1:0] vid_rdata,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_ack,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
`ifdef RAM_ARBITER_AUDIO_EN
  input  logic                  aud_req,
  input  logic [ADDR_WIDTH-1:0] aud_addr,
  output logic                  aud_ack,
  output logic [DATA_WIDTH-1:0] aud_rdata,
`endif
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_we,
  output logic [DATA_WIDTH-1:0] ram_din,
  input  logic [DATA_WIDTH-1:0] ram_dout
);

  gnt_e                  gnt_s;
  logic                  vid_ack_r;
  logic                  cpu_ack_r;
  logic [DATA_WIDTH-1:0] vid_rdata_r;
  logic [DATA_WIDTH-1:0] cpu_rdata_r;
`ifdef RAM_ARBITER_AUDIO_EN
  logic                  aud_ack_r;
  logic [DATA_WIDTH-1:0] aud_rdata_r;
`endif

  ram_arb_sel #(.VIDEO_MAX_BURST(VIDEO_MAX_BURST)) u_sel (
    .clk     (clk),
    .reset_n (reset_n),
    .vid_req (vid_req),
    .cpu_req (cpu_req),
`ifdef RAM_ARBITER_AUDIO_EN
    .aud_req (aud_req),
`endif
    .gnt     (gnt_s)
  );

  // RAM port mux driven from the granted requester
  always_comb begin
    ram_addr = {ADDR_WIDTH{1'b0}};
    ram_we   = 1'b0;
    ram_din  = {DATA_WIDTH{1'b0}};
    case (gnt_s)
      GNT_VID: ram_addr = vid_addr;
      GNT_CPU: begin
        ram_addr = cpu_addr;
        ram_we   = cpu_we;
        ram_din  = cpu_wdata;
      end
`ifdef RAM_ARBITER_AUDIO_EN
      GNT_AUD: ram_addr = aud_addr;
`endif
      default: ram_addr = {ADDR_WIDTH{1'b0}};
    endcase
  end

  // Ack pulses one clk after grant; read data captured on the ack cycle and held
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      vid_ack_r   <= 1'b0;
      cpu_ack_r   <= 1'b0;
      vid_rdata_r <= {DATA_WIDTH{1'b0}};
      cpu_rdata_r <= {DATA_WIDTH{1'b0}};
`ifdef RAM_ARBITER_AUDIO_EN
      aud_ack_r   <= 1'b0;
      aud_rdata_r <= {DATA_WIDTH{1'b0}};
`endif
    end else begin
      vid_ack_r <= (gnt_s == GNT_VID);
      cpu_ack_r <= (gnt_s == GNT_CPU);
      if (vid_ack_r) vid_rdata_r <= ram_dout;
      if (cpu_ack_r) cpu_rdata_r <= ram_dout;
`ifdef RAM_ARBITER_AUDIO_EN
      aud_ack_r <= (gnt_s == GNT_AUD);
      if (aud_ack_r) aud_rdata_r <= ram_dout;
`endif
    end
  end

  assign vid_ack   = vid_ack_r;
  assign cpu_ack   = cpu_ack_r;
  assign vid_rdata = vid_ack_r ? ram_dout : vid_rdata_r;
  assign cpu_rdata = cpu_ack_r ? ram_dout : cpu_rdata_r;
`ifdef RAM_ARBITER_AUDIO_EN
  assign aud_ack   = aud_ack_r;
  assign aud_rdata = aud_ack_r ? ram_dout : aud_rdata_r;
`endif

endmodule
